mesi_snoop_cache: RTL
=====================

# mesi_snoop_cache

Parametrised direct-mapped MESI snooping cache controller for one processor node on the shared snooping bus. It serves CPU reads and writes, issues read-miss, write-miss and invalidate bus transactions, and writes back dirty victims. It also answers snoops from the other nodes every cycle, and keeps saturating hit and miss counters. It supersedes the fixed 4-line per-processor cache with sized storage, a real request/ready handshake and an arbitrated bus port.

## Interface
- LINES, 4, number of lines; power of 2, ≥2; IDX_W = log2(LINES)
- TAG_W, 12, block address width; index = addr[IDX_W-1:0], stored tag = addr[TAG_W-1:IDX_W]
- DATA_W, 16, data word per line
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- cpu_req / cpu_we  in  1/1  request strobe, 1 = write
- cpu_addr / cpu_wdata  in  TAG_W/DATA_W  request address, write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- bus_req  out  1  bus request
- bus_grant  in  1  arbiter grant
- bus_cmd  out  2  00 none, 01 read miss, 10 write miss, 11 invalidate
- bus_addr  out  TAG_W  transaction address
- bus_shared  in  1  another node holds the line; sampled with bus_fill_valid
- bus_fill_valid / bus_fill_data  in  1/DATA_W  line data return
- wb_valid / wb_addr / wb_data  out  1/TAG_W/DATA_W  dirty victim write-back
- wb_ack  in  1  memory accepted write-back
- snp_valid / snp_cmd / snp_addr  in  1/2/TAG_W  snooped transaction; cmd encoding as bus_cmd
- snp_shared / snp_flush  out  1/1  registered snoop response: line present / dirty data supplied, memory access aborted
- snp_data  out  DATA_W  flushed data
- hit_count / miss_count  out  16/16  saturating at 0xFFFF

## Operation
- Line state encoding: I=00, S=01, E=10, M=11. Each line holds state, tag and data.
- FSM states and transitions:
  - IDLE: cpu_req → capture request, go to CHECK.
  - CHECK, hit (tag equal and state ≠ I):
    - read → DONE.
    - write on E/M → write data, state M, DONE.
    - write on S → BUS_REQ with cmd 11.
  - CHECK, miss with victim M → WB; otherwise → BUS_REQ with cmd 01 (read) or 10 (write).
  - WB: wb_valid held until wb_ack; victim state goes to I; → BUS_REQ.
  - BUS_REQ: bus_req held until bus_grant. In the grant cycle bus_cmd/bus_addr are driven for exactly one cycle; then → FILL (cmd 01/10) or → DONE (cmd 11, line becomes M with cpu_wdata).
  - FILL: wait for bus_fill_valid. Read installs E if !bus_shared, else S; cpu_rdata = fill data. Write installs M with cpu_wdata, overriding fill data. → DONE.
  - DONE: cpu_ready=1 for one cycle → IDLE.
- Counters: hit_count increments once per request judged a hit in CHECK. A write on S counts as a hit. Every other request increments miss_count.
- Snoop: evaluated every cycle in any FSM state, on a tag match with state ≠ I. Not evaluated while this node holds the grant or is in FILL.
  - cmd 01: M→S with flush; E→S; S stays S. snp_shared=1 in all three cases.
  - cmd 10: M→I with flush; E/S→I.
  - cmd 11: any→I, no flush.
- Upgrade race: a snoop that invalidates the pending S line before bus_grant converts the pending cmd 11 into cmd 10, and the FSM goes to FILL after grant.
- Snoop state update takes priority over the CPU-side write to the same line in the same cycle.

## Timing
- Reset values:
  - All line states I, tags 0, data 0.
  - All outputs 0: cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr, wb_valid, wb_addr, wb_data, snp_shared, snp_flush, snp_data, hit_count, miss_count.
  - FSM in IDLE.
- Reset mid-operation aborts any transaction on the next edge; no cpu_ready is generated.
- Hit latency: cpu_req sampled at edge N; cpu_ready high after edge N+2.
- Miss latency: N+2 to reach BUS_REQ, plus grant wait, plus fill wait, plus 1.
- cpu_req is ignored outside IDLE. Requests must be held stable only for the sampling edge.
- Snoop response registered: snp_shared/snp_flush/snp_data valid the cycle after snp_valid, for one cycle. The state change is visible at the same edge.
- bus_req stays high from BUS_REQ entry through the grant cycle and drops the cycle after.

## Test plan
- Reset, read 0x100; grant; fill 0x0010 with bus_shared=0 → bus_cmd=01/bus_addr=0x100 for one cycle, line0 E, cpu_rdata=0x0010, miss_count=1.
- Then write 0x100 ← 0x00AA → no bus_req, cpu_ready at N+2, line0 M, hit_count=1.
- Then read 0x104 (index 0) → wb_valid with wb_addr=0x100/wb_data=0x00AA until wb_ack, then bus_cmd=01 for 0x104.
- Line 0x100 in M, snp_valid cmd=01 addr=0x100 → next cycle snp_flush=1, snp_shared=1, snp_data=0x00AA; line becomes S.
- Line in S, write hit, snoop cmd=10 on same address before grant → issued bus_cmd=10, waits for fill, line ends M with cpu_wdata.
- Assert reset while in FILL → next cycle all outputs 0, all lines I, no cpu_ready.

Source files
------------

// File: rtl/mesi_snoop_cache.sv
// Direct-mapped MESI snooping cache controller for one node on a shared bus.
// Serves CPU reads/writes, issues bus transactions, writes back dirty victims
// and answers snoops from other nodes with a registered response.
module mesi_snoop_cache #(
  parameter int LINES  = 4,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [TAG_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [1:0]        bus_cmd,
  output logic [TAG_W-1:0]  bus_addr,
  input  logic              bus_shared,
  input  logic              bus_fill_valid,
  input  logic [DATA_W-1:0] bus_fill_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  input  logic              snp_valid,
  input  logic [1:0]        snp_cmd,
  input  logic [TAG_W-1:0]  snp_addr,
  output logic              snp_shared,
  output logic              snp_flush,
  output logic [DATA_W-1:0] snp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int STAG_W = TAG_W - IDX_W;

  localparam logic [1:0] L_I = 2'b00, L_S = 2'b01, L_E = 2'b10, L_M = 2'b11;
  localparam logic [1:0] CMD_NONE = 2'b00, CMD_RM = 2'b01, CMD_WM = 2'b10, CMD_INV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WB, S_BUS_REQ, S_FILL, S_DONE
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [TAG_W-1:0]  req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              snp_shared_q, snp_shared_d;
  logic              snp_flush_q, snp_flush_d;
  logic [DATA_W-1:0] snp_data_q, snp_data_d;
  logic [15:0]       hit_q, hit_d, miss_q, miss_d;

  logic [1:0]        line_state_q [LINES];
  logic [1:0]        line_state_d [LINES];
  logic [STAG_W-1:0] line_tag_q   [LINES];
  logic [STAG_W-1:0] line_tag_d   [LINES];
  logic [DATA_W-1:0] line_data_q  [LINES];
  logic [DATA_W-1:0] line_data_d  [LINES];

  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic [STAG_W-1:0] req_tag, snp_tag, cur_tag;
  logic [1:0]        cur_state, snp_line_state;
  logic [DATA_W-1:0] cur_data;
  logic              req_hit, snp_en, snp_hit, snp_kills_req, granted;

  assign req_idx        = req_addr_q[IDX_W-1:0];
  assign req_tag        = req_addr_q[TAG_W-1:IDX_W];
  assign snp_idx        = snp_addr[IDX_W-1:0];
  assign snp_tag        = snp_addr[TAG_W-1:IDX_W];
  assign cur_state      = line_state_q[req_idx];
  assign cur_tag        = line_tag_q[req_idx];
  assign cur_data       = line_data_q[req_idx];
  assign snp_line_state = line_state_q[snp_idx];
  assign req_hit        = (cur_state != L_I) && (cur_tag == req_tag);
  assign granted        = (fsm_q == S_BUS_REQ) && bus_grant;
  // Snoops are ignored while we own the bus or are receiving our own fill.
  assign snp_en         = snp_valid && !granted && (fsm_q != S_FILL);
  assign snp_hit        = snp_en && (snp_line_state != L_I) && (line_tag_q[snp_idx] == snp_tag);
  // A remote write-miss/invalidate on our pending line turns an upgrade into a write miss.
  assign snp_kills_req  = snp_hit && ((snp_cmd == CMD_WM) || (snp_cmd == CMD_INV)) &&
                          (snp_addr == req_addr_q);

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign bus_req    = (fsm_q == S_BUS_REQ);
  assign bus_cmd    = granted ? cmd_q : CMD_NONE;
  assign bus_addr   = granted ? req_addr_q : '0;
  assign wb_valid   = (fsm_q == S_WB);
  assign wb_addr    = wb_valid ? {cur_tag, req_idx} : '0;
  assign wb_data    = wb_valid ? cur_data : '0;
  assign snp_shared = snp_shared_q;
  assign snp_flush  = snp_flush_q;
  assign snp_data   = snp_data_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state: CPU-side FSM first, then snoop updates, which win on the same line.
  always_comb begin
    fsm_d        = fsm_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    cmd_d        = cmd_q;
    line_state_d = line_state_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    snp_shared_d = 1'b0;
    snp_flush_d  = 1'b0;
    snp_data_d   = '0;
    hit_d        = hit_q;
    miss_d       = miss_q;

    case (fsm_q)
      S_IDLE: if (cpu_req) begin
        req_addr_d  = cpu_addr;
        req_we_d    = cpu_we;
        req_wdata_d = cpu_wdata;
        fsm_d       = S_CHECK;
      end
      S_CHECK: if (req_hit) begin
        hit_d = sat_inc(hit_q);
        if (!req_we_q) begin
          fsm_d = S_DONE;
        end else if (cur_state == L_S) begin
          cmd_d = snp_kills_req ? CMD_WM : CMD_INV;
          fsm_d = S_BUS_REQ;
        end else begin
          line_data_d[req_idx]  = req_wdata_q;
          line_state_d[req_idx] = L_M;
          fsm_d = S_DONE;
        end
      end else begin
        miss_d = sat_inc(miss_q);
        cmd_d  = req_we_q ? CMD_WM : CMD_RM;
        fsm_d  = (cur_state == L_M) ? S_WB : S_BUS_REQ;
      end
      S_WB: if (wb_ack) begin
        line_state_d[req_idx] = L_I;
        fsm_d = S_BUS_REQ;
      end
      S_BUS_REQ: if (bus_grant) begin
        if (cmd_q == CMD_INV) begin
          line_data_d[req_idx]  = req_wdata_q;
          line_state_d[req_idx] = L_M;
          fsm_d = S_DONE;
        end else begin
          fsm_d = S_FILL;
        end
      end else if (snp_kills_req && (cmd_q == CMD_INV)) begin
        cmd_d = CMD_WM;
      end
      S_FILL: if (bus_fill_valid) begin
        line_tag_d[req_idx] = req_tag;
        if (req_we_q) begin
          line_data_d[req_idx]  = req_wdata_q;
          line_state_d[req_idx] = L_M;
        end else begin
          line_data_d[req_idx]  = bus_fill_data;
          line_state_d[req_idx] = bus_shared ? L_S : L_E;
        end
        fsm_d = S_DONE;
      end
      S_DONE: begin
        cpu_ready_d = 1'b1;
        cpu_rdata_d = cur_data;
        fsm_d       = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase

    if (snp_hit) begin
      case (snp_cmd)
        CMD_RM: begin
          line_state_d[snp_idx] = L_S;
          snp_shared_d = 1'b1;
          if (snp_line_state == L_M) begin
            snp_flush_d = 1'b1;
            snp_data_d  = line_data_q[snp_idx];
          end
        end
        CMD_WM: begin
          line_state_d[snp_idx] = L_I;
          if (snp_line_state == L_M) begin
            snp_flush_d = 1'b1;
            snp_data_d  = line_data_q[snp_idx];
          end
        end
        CMD_INV: line_state_d[snp_idx] = L_I;
        default: ;
      endcase
    end
  end

  // Register update for controller state, outputs and line storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      req_addr_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      cmd_q        <= CMD_NONE;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      snp_shared_q <= 1'b0;
      snp_flush_q  <= 1'b0;
      snp_data_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_state_q[i] <= L_I;
        line_tag_q[i]   <= '0;
        line_data_q[i]  <= '0;
      end
    end else begin
      fsm_q        <= fsm_d;
      req_addr_q   <= req_addr_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      cmd_q        <= cmd_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      snp_shared_q <= snp_shared_d;
      snp_flush_q  <= snp_flush_d;
      snp_data_q   <= snp_data_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      for (int i = 0; i < LINES; i++) begin
        line_state_q[i] <= line_state_d[i];
        line_tag_q[i]   <= line_tag_d[i];
        line_data_q[i]  <= line_data_d[i];
      end
    end
  end
endmodule
